fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write side of the async FIFO (`wdata`/`winc`/`wfull`) among `NREQ` requesters in the write clock domain. It grants one requester at a time for a burst of up to `BURST` beats, gates every beat with `wfull`, and re-arbitrates back-to-back with no idle cycle. It sits directly in front of the FIFO write port and runs on the FIFO write clock.

## Interface
- `DSIZE`, 8: data width; matches the FIFO `DSIZE`.
- `NREQ`, 4: number of requesters, ≥2.
- `BURST`, 4: maximum beats per grant, ≥1.
- `CW`, `$clog2(BURST)` (min 1): beat counter width (localparam).

Ports:
- `clk` in 1: write-domain clock, the same clock as the FIFO `wclk`.
- `rst_n` in 1: asynchronous active-low reset, tied to the same source as `wrst_n`.
- `req` in `NREQ`: per-requester request; high means data is valid on the requester's slice.
- `din` in `NREQ*DSIZE`: requester data; requester i occupies `[i*DSIZE +: DSIZE]`.
- `ack` out `NREQ`: one-hot beat-accepted strobe; the requester advances its data on `ack`.
- `gnt` out `NREQ`: registered one-hot current grant; all zeros when idle.
- `wdata` out `DSIZE`: to FIFO `wdata`; `din` slice selected by `gnt`.
- `winc` out 1: to FIFO `winc`.
- `wfull` in 1: from FIFO `wfull`.
- `busy` out 1: high in GRANT state.

## Operation
- State machine has two states.
  - IDLE: `gnt`=0. If any `req` bit is high, register the round-robin winner into `gnt`, clear `beat_cnt`, and go to GRANT.
  - GRANT: the granted index g is held in `gnt`.
- Round-robin search: starts at `ptr+1` and wraps modulo `NREQ`; the first set `req` bit wins. `ptr` is loaded with the winner index on every grant.
- Beat: occurs when `req[g] && !wfull` in GRANT. On a beat, `winc`=1, `ack[g]`=1, and `beat_cnt` increments.
- `winc` and `ack` are combinational from registered `gnt`/state, `req[g]` and `wfull`. They are never high in IDLE.
- `wdata` is the AND-OR mux of `din` by `gnt`. It is 0 when `gnt`=0.
- Grant ends when either condition holds:
  - (a) a beat occurs with `beat_cnt`==`BURST`-1;
  - (b) `req[g]` is low, which is not a beat.
- On grant end:
  - If any `req` bit is high, grant the round-robin winner searched from g+1 in the next cycle. State stays GRANT and `beat_cnt` is cleared. g itself can win again only if it is the sole requester.
  - Otherwise `gnt` goes to 0 and the state goes to IDLE.
- `wfull` high stalls the grant. The grant is held, `beat_cnt` is frozen, and `ack`/`winc` are 0. `wfull` never ends a grant.
- Requester rules:
  - A requester holds `din` stable while `req` is high and its `ack` is low.
  - A requester may drop `req` at any time; dropping `req` forfeits the rest of the burst.
- Reset values: state IDLE, `gnt`=0, `ack`=0, `winc`=0, `wdata`=0, `busy`=0, `beat_cnt`=0, `ptr`=`NREQ`-1, so requester 0 has the highest priority first.
- Reset asserted mid-burst takes effect immediately, asynchronously. The beat in that cycle is lost; the requester has seen no `ack` for it, so it retries.

## Timing
- Arbitration latency: `req` rising in IDLE at cycle n gives `gnt` at cycle n+1. The first `winc` occurs in cycle n+1 if `wfull`=0.
- Throughput: 1 beat per cycle while `req[g]` is high and `wfull` is low.
- Grant switch: no bubble after a BURST-end, and the next requester's first beat can occur in the following cycle. A `req` drop costs one cycle (the cycle where `req[g]` is low).
- `wfull` is sampled combinationally in the beat cycle, so FIFO registration of `wfull` guarantees no write is issued when full.

## Test plan
- Single requester: `BURST`=4, `req[2]` held for 6 data values 0x10–0x15. Required: `gnt`=0100 from cycle 1, `winc` high for 6 consecutive cycles, FIFO receives 0x10–0x15 in order, then `gnt`=0 and IDLE.
- All four `req` held, each with 8 beats, `BURST`=4. Required: grant order 0,1,2,3,0,1,2,3 with 4 beats each, `winc` continuously high for 32 cycles, no bubble at switches.
- `wfull` forced high for 3 cycles after beat 2 of requester 1. Required: `ack`/`winc` 0 for those 3 cycles, `gnt` still 0010, beats 3–4 follow, then the grant moves on.
- Requester 0 drops `req` after 2 beats while `req[3]` is high. Required: one cycle with `winc`=0, then `gnt`=1000 and requester 3 beats begin.
- Reset pulsed mid-burst of requester 2. Required: `gnt`, `ack`, `winc`, `busy` go to 0 immediately. After release with `req`=1111, the first grant goes to requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// A grant lasts up to BURST beats. Every beat is gated by wfull, and the next
// winner is granted back-to-back when a grant ends.
module fifo_wr_arbiter #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] din,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       gnt,
  output logic [DSIZE-1:0]      wdata,
  output logic                  winc,
  input  logic                  wfull,
  output logic                  busy
);

  localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [CW-1:0] LastBeat = CW'(BURST - 1);
  localparam logic [IW-1:0] PtrReset = IW'(NREQ - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] win_onehot;

  logic            in_grant;
  logic            req_g;
  logic            beat;
  logic            grant_end;

  // Round-robin search: first set req bit starting at ptr+1, wrapping.
  // ptr always holds the current/last winner, so this also serves the
  // "search from g+1" case at the end of a grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Decode the winner index into a one-hot grant vector.
  always_comb begin
    win_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      win_onehot[i] = (win_idx == IW'(i));
    end
  end

  // Beat and grant-end qualification from registered grant state.
  always_comb begin
    in_grant  = (state_q == StGrant);
    req_g     = |(req & gnt_q);
    beat      = in_grant && req_g && !wfull;
    // wfull only stalls; a grant ends on the last beat or on a req drop.
    grant_end = in_grant && (!req_g || (beat && (cnt_q == LastBeat)));
  end

  // Next-state logic for the grant FSM, pointer and beat counter.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StGrant;
          gnt_d   = win_onehot;
          ptr_d   = win_idx;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (grant_end) begin
          cnt_d = '0;
          if (win_found) begin
            gnt_d = win_onehot;
            ptr_d = win_idx;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset parks ptr at NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= PtrReset;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // AND-OR data mux by grant; zero when nothing is granted.
  always_comb begin
    wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      wdata = wdata | (din[i*DSIZE +: DSIZE] & {DSIZE{gnt_q[i]}});
    end
  end

  // Write strobe and per-requester accept, both combinational on the beat.
  always_comb begin
    winc = beat;
    ack  = beat ? gnt_q : '0;
    gnt  = gnt_q;
    busy = in_grant;
  end

  // Grant is one-hot or idle, and idle implies no grant.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q) && ((state_q == StGrant) == (gnt_q != '0)));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vector table plus a write scoreboard.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic [7:0]  wdata;
  logic        winc;
  logic        wfull;
  logic        busy;

  fifo_wr_arbiter #(
    .DSIZE(8),
    .NREQ (4),
    .BURST(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .din  (din),
    .ack  (ack),
    .gnt  (gnt),
    .wdata(wdata),
    .winc (winc),
    .wfull(wfull),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sc;
    logic [3:0] en;
    logic       wf;
    logic [3:0] g;
    logic       w;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  logic [7:0] srcmem[4][16];
  int         head[4];
  int         tail[4];
  logic [3:0] en;
  int         total;
  int         bad;

  function automatic void add(int sc, logic [3:0] e, logic wf, logic [3:0] g, logic w);
    vec_t v;
    v.sc = sc;
    v.en = e;
    v.wf = wf;
    v.g  = g;
    v.w  = w;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_src(int i, logic [7:0] d);
    srcmem[i][tail[i]] = d;
    tail[i]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  // Requester model: req while enabled and data remains; din holds queue head.
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i]         = en[i] && (head[i] < tail[i]);
      din[i*8 +: 8]  = (head[i] < tail[i]) ? srcmem[i][head[i]] : 8'h00;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 4'b0000;
    wfull = 1'b0;
    clear_src();
    sb.delete();
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(vec_t v, int j);
    logic [7:0] expd;
    @(negedge clk);
    en    = v.en;
    wfull = v.wf;
    drive();
    #1;
    chk($sformatf("sc%0d[%0d] gnt", v.sc, j), 32'(gnt), 32'(v.g));
    chk($sformatf("sc%0d[%0d] winc", v.sc, j), 32'(winc), 32'(v.w));
    chk($sformatf("sc%0d[%0d] ack", v.sc, j), 32'(ack), v.w ? 32'(v.g) : 32'd0);
    chk($sformatf("sc%0d[%0d] busy", v.sc, j), 32'(busy), 32'(|v.g));
    if (v.g == 4'b0000) chk($sformatf("sc%0d[%0d] wdata_idle", v.sc, j), 32'(wdata), 32'd0);
    if (winc) begin
      if (sb.size() == 0) begin
        chk($sformatf("sc%0d[%0d] sb_underflow", v.sc, j), 32'd1, 32'd0);
      end else begin
        expd = sb.pop_front();
        chk($sformatf("sc%0d[%0d] wdata", v.sc, j), 32'(wdata), 32'(expd));
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (ack[i] && head[i] < tail[i]) head[i]++;
    end
  endtask

  task automatic run_sc(int sc);
    for (int j = 0; j < tbl.size(); j++) begin
      if (tbl[j].sc == sc) step(tbl[j], j);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 4'b0000;
    wfull = 1'b0;
    req   = '0;
    din   = '0;

    // sc1: single requester 2, six beats across two bursts.
    add(1, 4'b0100, 1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 6; k++) add(1, 4'b0100, 1'b0, 4'b0100, 1'b1);
    add(1, 4'b0100, 1'b0, 4'b0100, 1'b0);
    add(1, 4'b0100, 1'b0, 4'b0000, 1'b0);
    // sc2: all four requesters, eight beats each, strict rotation.
    add(2, 4'b1111, 1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 32; k++) add(2, 4'b1111, 1'b0, 4'(1 << ((k / 4) % 4)), 1'b1);
    add(2, 4'b1111, 1'b0, 4'b1000, 1'b0);
    add(2, 4'b1111, 1'b0, 4'b0000, 1'b0);
    // sc3: wfull stall for three cycles after beat 2 of requester 1.
    add(3, 4'b0110, 1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 2; k++) add(3, 4'b0110, 1'b0, 4'b0010, 1'b1);
    for (int k = 0; k < 3; k++) add(3, 4'b0110, 1'b1, 4'b0010, 1'b0);
    for (int k = 0; k < 2; k++) add(3, 4'b0110, 1'b0, 4'b0010, 1'b1);
    for (int k = 0; k < 2; k++) add(3, 4'b0110, 1'b0, 4'b0100, 1'b1);
    add(3, 4'b0110, 1'b0, 4'b0100, 1'b0);
    add(3, 4'b0110, 1'b0, 4'b0000, 1'b0);
    // sc4: requester 0 drops after two beats; requester 3 takes over.
    add(4, 4'b1001, 1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 2; k++) add(4, 4'b1001, 1'b0, 4'b0001, 1'b1);
    add(4, 4'b1000, 1'b0, 4'b0001, 1'b0);
    for (int k = 0; k < 3; k++) add(4, 4'b1000, 1'b0, 4'b1000, 1'b1);
    add(4, 4'b1000, 1'b0, 4'b1000, 1'b0);
    add(4, 4'b1000, 1'b0, 4'b0000, 1'b0);
    // sc5: start of a burst that reset interrupts; sc6: after release.
    add(5, 4'b0100, 1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 2; k++) add(5, 4'b0100, 1'b0, 4'b0100, 1'b1);
    add(6, 4'b1111, 1'b0, 4'b0000, 1'b0);
    add(6, 4'b1111, 1'b0, 4'b0001, 1'b1);

    // Reset state.
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset winc", 32'(winc), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset wdata", 32'(wdata), 32'd0);

    do_reset();
    for (int k = 0; k < 6; k++) begin
      push_src(2, 8'(8'h10 + k));
      sb.push_back(8'(8'h10 + k));
    end
    run_sc(1);
    chk("sc1 sb_empty", 32'(sb.size()), 32'd0);

    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) push_src(i, 8'(8'h80 + i * 16 + k));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        for (int k = r * 4; k < r * 4 + 4; k++) sb.push_back(8'(8'h80 + i * 16 + k));
    run_sc(2);
    chk("sc2 sb_empty", 32'(sb.size()), 32'd0);

    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_src(1, 8'(8'h31 + k));
      sb.push_back(8'(8'h31 + k));
    end
    for (int k = 0; k < 2; k++) begin
      push_src(2, 8'(8'h41 + k));
      sb.push_back(8'(8'h41 + k));
    end
    run_sc(3);
    chk("sc3 sb_empty", 32'(sb.size()), 32'd0);

    do_reset();
    for (int k = 0; k < 4; k++) push_src(0, 8'(8'h50 + k));
    for (int k = 0; k < 3; k++) push_src(3, 8'(8'h60 + k));
    sb.push_back(8'h50);
    sb.push_back(8'h51);
    for (int k = 0; k < 3; k++) sb.push_back(8'(8'h60 + k));
    run_sc(4);
    chk("sc4 sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-burst: outputs must clear without waiting for a clock edge.
    do_reset();
    for (int k = 0; k < 6; k++) push_src(2, 8'(8'h70 + k));
    sb.push_back(8'h70);
    sb.push_back(8'h71);
    run_sc(5);
    @(negedge clk);
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst gnt", 32'(gnt), 32'd0);
    chk("midrst ack", 32'(ack), 32'd0);
    chk("midrst winc", 32'(winc), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst wdata", 32'(wdata), 32'd0);
    chk("sc5 sb_empty", 32'(sb.size()), 32'd0);
    clear_src();
    for (int i = 0; i < 4; i++) push_src(i, 8'(8'h90 + i));
    sb.push_back(8'h90);
    en = 4'b0000;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    run_sc(6);
    chk("sc6 sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
